// File: rtl/ibexc_mem_pkg.sv
// Shared types and helpers for the ibexc data memory responder.
// SECDED encoder is only referenced when IBEXC_MEM_INTG_EN is defined.
package ibexc_mem_pkg;

  localparam int unsigned MEM_TAG_BIT = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned INTG_W      = 7;

  typedef struct packed {
    logic        err;
    logic [32:0] rdata;
  } mem_resp_t;

  // Inverted SECDED(39,32) check bits, as used on the core data bus
  function automatic logic [INTG_W-1:0] intg_enc(input logic [DATA_W-1:0] d);
    logic [INTG_W-1:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return c ^ 7'h2A;
  endfunction

endpackage

// File: rtl/ibexc_data_mem_responder_if.sv
// Core data bus between the ibexc LSU (master) and a memory responder (slave).
interface ibexc_data_mem_responder_if;
  import ibexc_mem_pkg::*;

  logic                  req;
  logic                  is_cap;
  logic                  gnt;
  logic                  rvalid;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           addr;
  logic [MEM_TAG_BIT:0]  wdata;
  logic [INTG_W-1:0]     wdata_intg;
  logic [MEM_TAG_BIT:0]  rdata;
  logic [INTG_W-1:0]     rdata_intg;
  logic                  err;

  modport master (
    output req, is_cap, we, be, addr, wdata, wdata_intg,
    input  gnt, rvalid, rdata, rdata_intg, err
  );

  modport slave (
    input  req, is_cap, we, be, addr, wdata, wdata_intg,
    output gnt, rvalid, rdata, rdata_intg, err
  );

endinterface

// File: rtl/ibexc_mem_resp_pipe.sv
// Fixed-depth valid + response delay line with synchronous flush on reset.
// Each stage's payload only loads on a valid entry, so the output holds the last response.
module ibexc_mem_resp_pipe
  import ibexc_mem_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      in_valid,
  input  mem_resp_t in_resp,
  output logic      out_valid,
  output mem_resp_t out_resp
);

  logic [Depth-1:0] valid_q;
  mem_resp_t        resp_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) resp_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) resp_q[0] <= in_resp;
      for (int i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) resp_q[i] <= resp_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_resp  = resp_q[Depth-1];

endmodule

// File: rtl/ibexc_data_mem_responder.sv
// Memory-side responder for the ibexc data bus: tagged 33-bit SRAM model with grant stall,
// fixed response latency and outstanding limit. Optional integrity: IBEXC_MEM_INTG_EN.
module ibexc_data_mem_responder
  import ibexc_mem_pkg::*;
#(
  parameter int unsigned MemWords       = 4096,
  parameter logic [31:0] BaseAddr       = 32'h8000_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned GntStallCycles = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  ibexc_data_mem_responder_if.slave data
);

  localparam int unsigned IdxW      = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned OstW      = 3;
  localparam int unsigned StallW    = 4;
  localparam logic [31:0] SpanBytes = 32'(4 * MemWords);

  logic [MEM_TAG_BIT:0] mem_q [MemWords];
  logic [StallW-1:0]    stall_cnt_q;
  logic [OstW-1:0]      outstanding_q;

  logic                 gnt;
  logic                 hit;
  logic                 intg_ok;
  logic                 wr_en;
  logic [31:0]          offset;
  logic [IdxW-1:0]      idx;
  logic [MEM_TAG_BIT:0] word;
  logic [MEM_TAG_BIT:0] wr_word;
  mem_resp_t            resp_d;
  mem_resp_t            resp_q;
  logic                 resp_valid;

  // A response leaving the pipe this cycle frees its slot for a same-cycle grant
  assign gnt = data.req && (stall_cnt_q == '0) &&
               ((outstanding_q - OstW'(data.rvalid)) < OstW'(MaxOutstanding));

  assign offset = data.addr - BaseAddr;
  assign hit    = (data.addr >= BaseAddr) && (offset < SpanBytes);
  assign idx    = offset[IdxW+1:2];
  assign word   = mem_q[idx];

  always_comb begin
    wr_word = word;
    for (int b = 0; b < 4; b++) begin
      if (data.be[b]) wr_word[8*b +: 8] = data.wdata[8*b +: 8];
    end
    // Only a full-word capability store may set the tag
    wr_word[MEM_TAG_BIT] = data.is_cap && (data.be == 4'hF) && data.wdata[MEM_TAG_BIT];
    resp_d = '0;
    wr_en  = 1'b0;
    if (!hit) begin
      resp_d.err = 1'b1;
    end else if (data.we) begin
      resp_d.err = !intg_ok;
      wr_en      = gnt && intg_ok;
    end else begin
      resp_d.rdata = {word[MEM_TAG_BIT] & data.is_cap, word[DATA_W-1:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[idx] <= wr_word;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q   <= StallW'(GntStallCycles);
      outstanding_q <= '0;
    end else begin
      if (gnt) begin
        stall_cnt_q <= StallW'(GntStallCycles);
      end else if (data.req && (stall_cnt_q != '0)) begin
        stall_cnt_q <= stall_cnt_q - StallW'(1);
      end
      outstanding_q <= outstanding_q + OstW'(gnt) - OstW'(data.rvalid);
    end
  end

  ibexc_mem_resp_pipe #(
    .Depth (RespLatency)
  ) u_resp_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_valid  (gnt),
    .in_resp   (resp_d),
    .out_valid (resp_valid),
    .out_resp  (resp_q)
  );

  assign data.gnt    = gnt;
  assign data.rvalid = resp_valid;
  assign data.rdata  = resp_q.rdata;
  assign data.err    = resp_q.err;

`ifdef IBEXC_MEM_INTG_EN
  assign intg_ok         = (intg_enc(data.wdata[DATA_W-1:0]) == data.wdata_intg);
  assign data.rdata_intg = intg_enc(resp_q.rdata[DATA_W-1:0]);
`else
  logic unused_intg;
  assign intg_ok         = 1'b1;
  assign data.rdata_intg = '0;
  assign unused_intg     = ^data.wdata_intg;
`endif

  assert property (@(posedge clk_i) disable iff (!rst_ni) data.rvalid |-> (outstanding_q != '0));

endmodule
